// File: rtl/channel_status_collector.sv
// Rebuilds the 192-bit channel-status block of one subframe channel and publishes
// bits 31..0 plus block flags. Define CHSTAT_CRC_EN to build the byte-23 CRCC checker.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an accepted subframe carrying preamble B
// COLLECT | storing C bits 1..191 of the current block
// CHECK   | one cycle after bit 191; IDLE rules still apply to vin here
module channel_status_collector #(
    parameter logic CHANNEL_SEL = 1'b0,
    parameter int   ERR_CNT_W   = 8
) (
    input  logic                 clk_60mhz,
    input  logic                 rst,
    input  logic                 vin,
    input  logic                 cbit,
    input  logic                 pre_b,
    input  logic                 channel,
    output logic [31:0]          status_word,
    output logic                 status_valid,
    output logic                 professional,
    output logic                 crc_ok,
    output logic                 short_block,
    output logic [ERR_CNT_W-1:0] crc_err_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        start;
    logic        store;
    logic        last;
    logic        restart;
    logic        block_ok;
    logic [7:0]  bitcnt;
    logic [31:0] low_bits;

    assign accept = vin && (channel == CHANNEL_SEL);
    assign busy   = (state == COLLECT);

    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        store     = 1'b0;
        last      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE, CHECK: begin
                state_nxt = IDLE;
                if (accept && pre_b) begin
                    start     = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (pre_b) begin
                        start   = 1'b1;
                        restart = 1'b1;
                    end else begin
                        store = 1'b1;
                        if (bitcnt == 8'd191) begin
                            last      = 1'b1;
                            state_nxt = CHECK;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the edge that takes bit 191, so they are visible in CHECK.
    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            bitcnt       <= 8'd0;
            low_bits     <= 32'd0;
            status_word  <= 32'd0;
            status_valid <= 1'b0;
            professional <= 1'b0;
            crc_ok       <= 1'b0;
            short_block  <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            short_block  <= restart;
            if (start) begin
                bitcnt      <= 8'd1;
                low_bits[0] <= cbit;
            end else if (store) begin
                bitcnt <= bitcnt + 8'd1;
                if (bitcnt < 8'd32) begin
                    low_bits[bitcnt[4:0]] <= cbit;
                end
            end
            if (last) begin
                status_word  <= low_bits;
                professional <= low_bits[0];
                crc_ok       <= block_ok;
                status_valid <= 1'b1;
            end
        end
    end

`ifdef CHSTAT_CRC_EN
    logic [7:0]           crc;
    logic [6:0]           rx_low;
    logic                 crc_match;
    logic [ERR_CNT_W-1:0] err_count;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    endfunction

    // Bits 184..190 are kept here; bit 191 is taken straight from cbit on the final edge.
    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            crc    <= 8'hFF;
            rx_low <= 7'd0;
        end else if (start) begin
            crc <= crc_step(8'hFF, cbit);
        end else if (store) begin
            if (bitcnt < 8'd184) begin
                crc <= crc_step(crc, cbit);
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (bitcnt[2:0] == 3'(i)) begin
                        rx_low[i] <= cbit;
                    end
                end
            end
        end
    end

    assign crc_match = (crc == {cbit, rx_low});
    assign block_ok  = !low_bits[0] || crc_match;

    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            err_count <= '0;
        end else if (last && !block_ok && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    assign crc_err_count = err_count;
`else
    assign block_ok      = 1'b1;
    assign crc_err_count = '0;
`endif

endmodule

// File: tb/tb_channel_status_collector.sv
// Scoreboard bench for channel_status_collector: stimulus pushes expected block
// results, a negedge monitor pops and compares on every status_valid pulse.
module tb_channel_status_collector;

    localparam int W = 8;
`ifdef CHSTAT_CRC_EN
    localparam int N_SAT = 300;
    localparam int SAT_EXP = 255;
`else
    localparam int N_SAT = 3;
    localparam int SAT_EXP = 0;
`endif

    logic         clk_60mhz = 1'b0;
    logic         rst = 1'b1;
    logic         vin = 1'b0;
    logic         cbit = 1'b0;
    logic         pre_b = 1'b0;
    logic         channel = 1'b0;
    logic [31:0]  status_word;
    logic         status_valid;
    logic         professional;
    logic         crc_ok;
    logic         short_block;
    logic [W-1:0] crc_err_count;
    logic         busy;

    typedef struct packed {
        logic [31:0]  word;
        logic         prof;
        logic         ok;
        logic [W-1:0] errs;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          short_seen = 0;
    int          err_model = 0;
    logic [31:0] last_word = 32'd0;

    channel_status_collector #(.CHANNEL_SEL(1'b0), .ERR_CNT_W(W)) dut (
        .clk_60mhz    (clk_60mhz),
        .rst          (rst),
        .vin          (vin),
        .cbit         (cbit),
        .pre_b        (pre_b),
        .channel      (channel),
        .status_word  (status_word),
        .status_valid (status_valid),
        .professional (professional),
        .crc_ok       (crc_ok),
        .short_block  (short_block),
        .crc_err_count(crc_err_count),
        .busy         (busy)
    );

    always #8 clk_60mhz = ~clk_60mhz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_calc(input logic [191:0] b);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 0; i < 184; i++) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [191:0] mk(input logic [31:0] low);
        logic [191:0] b;
        b = '0;
        b[31:0] = low;
        return b;
    endfunction

    function automatic logic [191:0] prof_blk(input logic [7:0] byte1);
        logic [191:0] b;
        b = '0;
        b[7:0]     = 8'h01;
        b[15:8]    = byte1;
        b[191:184] = crc_calc(b);
        return b;
    endfunction

    always @(negedge clk_60mhz) begin
        exp_t e;
        if (short_block === 1'b1) short_seen++;
        if (status_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_status_valid: got pulse want none");
            end else begin
                e = sbq.pop_front();
                check("status_word", status_word, e.word);
                check("professional", professional, e.prof);
                check("crc_ok", crc_ok, e.ok);
                check("crc_err_count", crc_err_count, e.errs);
            end
        end
    end

    task automatic sub(input logic ch, input logic pb, input logic c);
        vin = 1'b1; channel = ch; pre_b = pb; cbit = c;
        @(posedge clk_60mhz); #1;
        vin = 1'b0; channel = 1'b0; pre_b = 1'b0; cbit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_60mhz);
        #1;
    endtask

    // Sends frames first..191 of blk on channel A; optional channel-B noise between them.
    task automatic run_block(input logic [191:0] blk, input bit noise, input int first);
        exp_t e;
        logic ok;
        ok = 1'b1;
`ifdef CHSTAT_CRC_EN
        if (blk[0]) ok = (crc_calc(blk) == blk[191:184]);
        if (!ok && err_model < 255) err_model++;
`endif
        e.word = blk[31:0];
        e.prof = blk[0];
        e.ok   = ok;
        e.errs = err_model[W-1:0];
        sbq.push_back(e);
        last_word = blk[31:0];
        for (int i = first; i < 192; i++) begin
            if (noise && i > 0) sub(1'b1, (i == 10), 1'b1);
            sub(1'b0, (i == 0), blk[i]);
        end
        check("latency_valid", status_valid, 1'b1);
    endtask

    task automatic check_reset_vals();
        check("rst_status_word", status_word, 32'd0);
        check("rst_status_valid", status_valid, 1'b0);
        check("rst_professional", professional, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_short_block", short_block, 1'b0);
        check("rst_crc_err_count", crc_err_count, '0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        logic [191:0] pro;
        logic [191:0] pro_bad;
        logic [191:0] blk;
        int           short0;

        repeat (3) @(posedge clk_60mhz);
        #1;
        check_reset_vals();
        rst = 1'b0;
        idle(2);

        // consumer block with channel-B noise, including a B-channel pre_b
        run_block(mk(32'h0200_0104), 1'b1, 0);
        idle(1);
        check("idle_after_check", busy, 1'b0);
        check("no_short_from_b", short_seen, 0);

        // professional good, then byte 23 bit 3 flipped
        pro = prof_blk(8'h00);
        run_block(pro, 1'b0, 0);
        idle(3);
        pro_bad = pro;
        pro_bad[187] = ~pro_bad[187];
        run_block(pro_bad, 1'b0, 0);
        idle(2);
        check("err_count_after_bad", crc_err_count, SAT_EXP == 0 ? 0 : 1);

        // premature block start at frame 100
        short0 = short_seen;
        blk = mk(32'h1234_5678);
        for (int i = 0; i < 100; i++) sub(1'b0, (i == 0), blk[i]);
        check("busy_collect", busy, 1'b1);
        blk = mk(32'hA5A5_5A5C);
        sub(1'b0, 1'b1, blk[0]);
        check("short_pulse", short_block, 1'b1);
        idle(1);
        check("short_one_cycle", short_block, 1'b0);
        check("short_word_hold", status_word, last_word);
        check("short_still_busy", busy, 1'b1);
        run_block(blk, 1'b0, 1);
        idle(2);
        check("short_count", short_seen - short0, 1);

        // back-to-back: next pre_b lands in the CHECK cycle
        run_block(mk(32'h0F0F_F0F0), 1'b0, 0);
        run_block(prof_blk(8'h5A), 1'b0, 0);
        idle(3);

        // reset at frame 50, coincident with a pre_b vin
        for (int i = 0; i < 50; i++) sub(1'b0, (i == 0), 1'b1);
        rst = 1'b1;
        sub(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        check_reset_vals();
        err_model = 0;
        for (int i = 0; i < 50; i++) sub(1'b0, 1'b0, 1'b1);
        check("no_restart_wo_preb", busy, 1'b0);
        run_block(mk(32'h8000_0002), 1'b0, 0);
        idle(2);

        // back-to-back bad professional blocks: counter saturation
        for (int n = 0; n < N_SAT; n++) run_block(pro_bad, 1'b0, 0);
        idle(2);
        check("err_saturate", crc_err_count, SAT_EXP);

        idle(5);
        check("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
